// File: rtl/modulo_escalonador_transferencia_rolhas_pkg.sv
// Shared constants, state encoding and grant codes
// for the cork-buffer transfer scheduler.
package modulo_escalonador_transferencia_rolhas_pkg;

    localparam int LOTE_DEF    = 20;
    localparam int CAP_SEC_DEF = 99;
    localparam int CAP_PRI_DEF = 31;
    localparam int W_SEC_DEF   = 7;
    localparam int W_PRI_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OPER  = 2'b01,
        TRANS = 2'b10,
        FIM   = 2'b11
    } estado_t;

    localparam logic [1:0] CONC_NADA = 2'b00;
    localparam logic [1:0] CONC_OP   = 2'b01;
    localparam logic [1:0] CONC_TR   = 2'b10;

endpackage

// File: rtl/modulo_escalonador_transferencia_rolhas_arbitro.sv
// Two-requester round-robin arbiter; bit 0 = operator,
// bit 1 = transfer. Only ties move the last-grant pointer.
module modulo_arbitro_rr2
    import modulo_escalonador_transferencia_rolhas_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_tr_q;
    logic last_tr_d;

    // Lone requester wins; a tie goes to whoever lost the last tie.
    always_comb begin
        gnt_o     = CONC_NADA;
        last_tr_d = last_tr_q;
        unique case (req_i)
            2'b01:   gnt_o = CONC_OP;
            2'b10:   gnt_o = CONC_TR;
            2'b11:   gnt_o = last_tr_q ? CONC_OP : CONC_TR;
            default: gnt_o = CONC_NADA;
        endcase
        if (upd_i && (req_i == 2'b11)) begin
            last_tr_d = gnt_o[1];
        end
    end

    // Last-grant flip-flop; reset favours transfer on the first tie.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            last_tr_q <= 1'b0;
        end else begin
            last_tr_q <= last_tr_d;
        end
    end

endmodule

// File: rtl/modulo_escalonador_transferencia_rolhas.sv
// Sequences operator reloads and lot transfers onto the
// secondary/main cork buffer counters, one step per clock.
module modulo_escalonador_transferencia_rolhas
    import modulo_escalonador_transferencia_rolhas_pkg::*;
#(
    parameter int LOTE    = LOTE_DEF,
    parameter int CAP_SEC = CAP_SEC_DEF,
    parameter int CAP_PRI = CAP_PRI_DEF,
    parameter int W_SEC   = W_SEC_DEF,
    parameter int W_PRI   = W_PRI_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             habilita,
    input  logic             vedacao,
    input  logic             req_operador,
    input  logic [W_SEC-1:0] qtd_operador,
    input  logic             req_transfer,
    input  logic [W_SEC-1:0] buf_sec,
    input  logic [W_PRI-1:0] buf_pri,
    output logic             sec_en,
    output logic             sec_up,
    output logic             pri_inc,
    output logic             ocupado,
    output logic [1:0]       concede,
    output logic             fim_op,
    output logic             fim_tr,
    output logic             erro
);

    localparam logic [W_SEC:0]   CAP_SEC_W = CAP_SEC[W_SEC:0];
    localparam logic [W_SEC-1:0] LOTE_S    = LOTE[W_SEC-1:0];
    localparam logic [W_PRI:0]   LOTE_P    = LOTE[W_PRI:0];
    localparam logic [W_PRI:0]   CAP_PRI_W = CAP_PRI[W_PRI:0];

    estado_t          state_q, state_d;
    logic [W_SEC-1:0] rest_q, rest_d;
    logic [W_SEC-1:0] qtd_q, qtd_d;
    logic [1:0]       conc_q, conc_d;
    logic             pend_op_q, pend_op_d;
    logic             pend_tr_q, pend_tr_d;
    logic             sec_en_q, sec_en_d;
    logic             sec_up_q, sec_up_d;
    logic             pri_inc_q, pri_inc_d;
    logic             fim_op_q, fim_op_d;
    logic             fim_tr_q, fim_tr_d;
    logic             erro_q, erro_d;

    logic             dup_op, dup_tr;
    logic             acc_op, acc_tr;
    logic             eff_op, eff_tr;
    logic [W_SEC-1:0] qtd_eff;
    logic [W_SEC:0]   soma_op;
    logic [W_PRI:0]   soma_tr;
    logic             op_ok, tr_ok;
    logic             pick;
    logic [1:0]       gnt;
    logic [W_SEC-1:0] rest_nx;

    assign dup_op  = pend_op_q || ((state_q != IDLE) && (conc_q == CONC_OP));
    assign dup_tr  = pend_tr_q || ((state_q != IDLE) && (conc_q == CONC_TR));
    assign acc_op  = req_operador && !dup_op;
    assign acc_tr  = req_transfer && !dup_tr;
    assign eff_op  = pend_op_q || acc_op;
    assign eff_tr  = pend_tr_q || acc_tr;
    assign qtd_eff = pend_op_q ? qtd_q : qtd_operador;
    assign soma_op = {1'b0, buf_sec} + {1'b0, qtd_eff};
    assign soma_tr = {1'b0, buf_pri} + LOTE_P;
    assign op_ok   = (qtd_eff != '0) && (soma_op <= CAP_SEC_W);
    assign tr_ok   = (buf_sec >= LOTE_S) && (soma_tr <= CAP_PRI_W);
    assign pick    = (state_q == IDLE) && habilita && (eff_op || eff_tr);
    assign rest_nx = rest_q - {{(W_SEC-1){1'b0}}, sec_en_q};

    modulo_arbitro_rr2 u_arb (
        .clk   (clk),
        .clr   (clr),
        .req_i ({eff_tr, eff_op}),
        .upd_i (pick),
        .gnt_o (gnt)
    );

    // Request capture, grant/validation and step sequencing.
    always_comb begin
        state_d   = state_q;
        rest_d    = rest_q;
        conc_d    = conc_q;
        qtd_d     = acc_op ? qtd_operador : qtd_q;
        pend_op_d = eff_op;
        pend_tr_d = eff_tr;
        sec_en_d  = 1'b0;
        sec_up_d  = 1'b0;
        pri_inc_d = 1'b0;
        fim_op_d  = 1'b0;
        fim_tr_d  = 1'b0;
        erro_d    = (req_operador && dup_op) || (req_transfer && dup_tr);
        unique case (state_q)
            IDLE: begin
                if (pick) begin
                    if (gnt == CONC_OP) begin
                        pend_op_d = 1'b0;
                        if (op_ok) begin
                            state_d = OPER;
                            rest_d  = qtd_eff;
                            conc_d  = CONC_OP;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end else begin
                        pend_tr_d = 1'b0;
                        if (tr_ok) begin
                            state_d = TRANS;
                            rest_d  = LOTE_S;
                            conc_d  = CONC_TR;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                end
            end
            OPER: begin
                rest_d = rest_nx;
                if (rest_nx == '0) begin
                    state_d  = FIM;
                    fim_op_d = 1'b1;
                end else begin
                    sec_en_d = habilita;
                    sec_up_d = habilita;
                end
            end
            TRANS: begin
                rest_d = rest_nx;
                if (rest_nx == '0) begin
                    state_d  = FIM;
                    fim_tr_d = 1'b1;
                end else begin
                    sec_en_d  = habilita && !vedacao;
                    pri_inc_d = habilita && !vedacao;
                end
            end
            FIM: begin
                state_d = IDLE;
                conc_d  = CONC_NADA;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, pending flags and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            rest_q    <= '0;
            qtd_q     <= '0;
            conc_q    <= CONC_NADA;
            pend_op_q <= 1'b0;
            pend_tr_q <= 1'b0;
            sec_en_q  <= 1'b0;
            sec_up_q  <= 1'b0;
            pri_inc_q <= 1'b0;
            fim_op_q  <= 1'b0;
            fim_tr_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rest_q    <= rest_d;
            qtd_q     <= qtd_d;
            conc_q    <= conc_d;
            pend_op_q <= pend_op_d;
            pend_tr_q <= pend_tr_d;
            sec_en_q  <= sec_en_d;
            sec_up_q  <= sec_up_d;
            pri_inc_q <= pri_inc_d;
            fim_op_q  <= fim_op_d;
            fim_tr_q  <= fim_tr_d;
            erro_q    <= erro_d;
        end
    end

    assign sec_en  = sec_en_q;
    assign sec_up  = sec_up_q;
    assign pri_inc = pri_inc_q;
    assign ocupado = (state_q != IDLE);
    assign concede = conc_q;
    assign fim_op  = fim_op_q;
    assign fim_tr  = fim_tr_q;
    assign erro    = erro_q;

endmodule

// File: tb/tb_modulo_escalonador_transferencia_rolhas.sv
// Self-checking bench for the cork transfer scheduler:
// per-request arithmetic model versus observed step counts.
module tb_modulo_escalonador_transferencia_rolhas;

    localparam int LOTE    = 20;
    localparam int CAP_SEC = 99;
    localparam int CAP_PRI = 31;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       habilita = 1'b0;
    logic       vedacao = 1'b0;
    logic       req_operador = 1'b0;
    logic [6:0] qtd_operador = '0;
    logic       req_transfer = 1'b0;
    logic [6:0] buf_sec = '0;
    logic [4:0] buf_pri = '0;
    logic       sec_en, sec_up, pri_inc, ocupado;
    logic [1:0] concede;
    logic       fim_op, fim_tr, erro;

    int total = 0;
    int bad = 0;

    int c_up, c_dn, c_pri, c_fop, c_ftr, c_err, c_ocup, c_viol;
    int first_en, last_en, first_gnt;
    logic [1:0] grants[$];
    int p_op_at = -1, p_tr_at = -1;
    logic [6:0] p_qtd = '0;
    int hab_from = -1, hab_len = 0, ved_from = -1, ved_len = 0;

    modulo_escalonador_transferencia_rolhas dut (
        .clk          (clk),
        .clr          (clr),
        .habilita     (habilita),
        .vedacao      (vedacao),
        .req_operador (req_operador),
        .qtd_operador (qtd_operador),
        .req_transfer (req_transfer),
        .buf_sec      (buf_sec),
        .buf_pri      (buf_pri),
        .sec_en       (sec_en),
        .sec_up       (sec_up),
        .pri_inc      (pri_inc),
        .ocupado      (ocupado),
        .concede      (concede),
        .fim_op       (fim_op),
        .fim_tr       (fim_tr),
        .erro         (erro)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {sec_en, sec_up, pri_inc, ocupado, concede, fim_op, fim_tr, erro};
    endfunction

    // Runs n cycles starting at posedge+1, driving scheduled inputs
    // and tallying what the outputs did in each cycle.
    task automatic observe(input int n);
        logic hab_prev, ved_prev;
        logic [1:0] prev_conc;
        c_up = 0; c_dn = 0; c_pri = 0; c_fop = 0; c_ftr = 0;
        c_err = 0; c_ocup = 0; c_viol = 0;
        first_en = -1; last_en = -1; first_gnt = -1;
        grants.delete();
        prev_conc = concede;
        hab_prev = habilita;
        ved_prev = vedacao;
        for (int i = 0; i < n; i++) begin
            if (sec_en) begin
                if (first_en < 0) first_en = i;
                last_en = i;
                if (sec_up) c_up++; else c_dn++;
            end
            if (pri_inc) c_pri++;
            if (fim_op) c_fop++;
            if (fim_tr) c_ftr++;
            if (erro) c_err++;
            if (ocupado) c_ocup++;
            if ((sec_en || pri_inc) && (!ocupado || concede == 2'b00)) c_viol++;
            if ((sec_en || pri_inc) && (fim_op || fim_tr)) c_viol++;
            if (pri_inc !== (sec_en && !sec_up)) c_viol++;
            if (!ocupado && concede != 2'b00) c_viol++;
            if (!hab_prev && (sec_en || pri_inc)) c_viol++;
            if (ved_prev && pri_inc) c_viol++;
            if (concede != prev_conc && concede != 2'b00) begin
                grants.push_back(concede);
                if (first_gnt < 0) first_gnt = i;
            end
            prev_conc = concede;
            habilita = !(i >= hab_from && i < hab_from + hab_len);
            vedacao = (i >= ved_from && i < ved_from + ved_len);
            req_operador = (i == p_op_at);
            req_transfer = (i == p_tr_at);
            qtd_operador = p_qtd;
            hab_prev = habilita;
            ved_prev = vedacao;
            @(posedge clk);
            #1;
        end
        habilita = 1'b1; vedacao = 1'b0;
        req_operador = 1'b0; req_transfer = 1'b0;
        p_op_at = -1; p_tr_at = -1;
        hab_from = -1; hab_len = 0; ved_from = -1; ved_len = 0;
    endtask

    task automatic apply_reset();
        #2 clr = 1'b0;
        @(posedge clk);
        #1 clr = 1'b1;
    endtask

    task automatic test_reset();
        #3 clr = 1'b0;
        #2;
        total++;
        if (outs() !== 9'd0) begin
            bad++; $display("FAIL reset_hold got=%b exp=0", outs());
        end
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        buf_sec = 7'd30;
        qtd_operador = 7'd5;
        req_operador = 1'b1;
        @(posedge clk);
        #1 req_operador = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ocupado !== 1'b0) begin
            bad++; $display("FAIL paused_grant got=%b exp=0", ocupado);
        end
        #2 clr = 1'b0;
        #1;
        total++;
        if (outs() !== 9'd0) begin
            bad++; $display("FAIL reset_pending got=%b exp=0", outs());
        end
        @(posedge clk);
        #1 clr = 1'b1;
        habilita = 1'b1;
        observe(6);
        total++;
        if (c_ocup != 0 || c_err != 0 || c_viol != 0) begin
            bad++;
            $display("FAIL pending_discarded ocup=%0d err=%0d viol=%0d exp=0", c_ocup, c_err, c_viol);
        end
    endtask

    task automatic test_operador();
        buf_sec = 7'd30; p_qtd = 7'd5; p_op_at = 0;
        observe(12);
        total++;
        if (first_gnt != 1 || grants.size() != 1 || grants[0] !== 2'b01) begin
            bad++; $display("FAIL op_grant at=%0d n=%0d exp at=1 n=1 code=01", first_gnt, grants.size());
        end
        total++;
        if (c_up != 5 || last_en - first_en != 4) begin
            bad++; $display("FAIL op_steps got=%0d span=%0d exp=5 span=4", c_up, last_en - first_en);
        end
        total++;
        if (c_ocup != 7 || c_fop != 1 || c_viol != 0) begin
            bad++; $display("FAIL op_total ocup=%0d fim=%0d viol=%0d exp 7 1 0", c_ocup, c_fop, c_viol);
        end
    endtask

    task automatic test_transfer_stall();
        buf_sec = 7'd40; buf_pri = 5'd3; p_tr_at = 0;
        ved_from = 8; ved_len = 4;
        observe(35);
        total++;
        if (c_dn != LOTE || c_pri != LOTE || c_up != 0) begin
            bad++; $display("FAIL tr_steps dn=%0d pri=%0d up=%0d exp 20 20 0", c_dn, c_pri, c_up);
        end
        total++;
        if (last_en - first_en + 1 != LOTE + 4) begin
            bad++; $display("FAIL tr_stall_window got=%0d exp=24", last_en - first_en + 1);
        end
        total++;
        if (c_ftr != 1 || c_fop != 0 || c_viol != 0) begin
            bad++; $display("FAIL tr_end ftr=%0d fop=%0d viol=%0d exp 1 0 0", c_ftr, c_fop, c_viol);
        end
    endtask

    task automatic test_arbitration();
        apply_reset();
        buf_sec = 7'd40; buf_pri = 5'd3; p_qtd = 7'd5;
        p_op_at = 0; p_tr_at = 0;
        observe(45);
        total++;
        if (grants.size() != 2 || grants[0] !== 2'b10 || grants[1] !== 2'b01) begin
            bad++; $display("FAIL tie_first n=%0d exp order 10,01", grants.size());
        end
        total++;
        if (c_dn != LOTE || c_up != 5 || c_fop != 1 || c_ftr != 1 || c_viol != 0) begin
            bad++; $display("FAIL tie_first_steps dn=%0d up=%0d viol=%0d exp 20 5 0", c_dn, c_up, c_viol);
        end
        p_op_at = 0; p_tr_at = 0;
        observe(45);
        total++;
        if (grants.size() != 2 || grants[0] !== 2'b01 || grants[1] !== 2'b10) begin
            bad++; $display("FAIL tie_second n=%0d exp order 01,10", grants.size());
        end
    endtask

    task automatic run_single(input bit is_op, input int bs, input int bp, input int q, input string nm);
        bit ok;
        int n, steps, fims;
        ok = is_op ? (q != 0 && bs + q <= CAP_SEC) : (bs >= LOTE && bp + LOTE <= CAP_PRI);
        n = is_op ? q : LOTE;
        buf_sec = 7'(bs); buf_pri = 5'(bp); p_qtd = 7'(q);
        if (is_op) p_op_at = 0; else p_tr_at = 0;
        observe(n + 6);
        steps = is_op ? c_up : c_dn;
        fims = is_op ? c_fop : c_ftr;
        total++;
        if (c_err != (ok ? 0 : 1)) begin
            bad++; $display("FAIL %s erro got=%0d exp=%0d", nm, c_err, ok ? 0 : 1);
        end
        total++;
        if (steps != (ok ? n : 0) || c_up + c_dn != steps) begin
            bad++; $display("FAIL %s steps got=%0d exp=%0d", nm, c_up + c_dn, ok ? n : 0);
        end
        total++;
        if (fims != (ok ? 1 : 0) || c_ocup != (ok ? n + 2 : 0) || c_viol != 0) begin
            bad++;
            $display("FAIL %s fim=%0d ocup=%0d viol=%0d exp %0d %0d 0", nm, fims, c_ocup, c_viol, ok ? 1 : 0, ok ? n + 2 : 0);
        end
    endtask

    task automatic test_reject();
        run_single(1'b1, 95, 0, 5, "op_over_cap");
        run_single(1'b1, 94, 0, 5, "op_at_cap");
        run_single(1'b1, 50, 0, 0, "op_zero");
        run_single(1'b0, 19, 0, 0, "tr_sec_low");
        run_single(1'b0, 20, 0, 0, "tr_sec_edge");
        run_single(1'b0, 40, 12, 0, "tr_pri_over");
        run_single(1'b0, 40, 11, 0, "tr_pri_edge");
    endtask

    task automatic test_habilita();
        buf_sec = 7'd10; p_qtd = 7'd8; p_op_at = 0;
        hab_from = 4; hab_len = 5;
        observe(25);
        total++;
        if (c_up != 8 || c_fop != 1 || c_viol != 0) begin
            bad++; $display("FAIL pause_steps up=%0d fim=%0d viol=%0d exp 8 1 0", c_up, c_fop, c_viol);
        end
        total++;
        if (c_ocup != 15) begin
            bad++; $display("FAIL pause_hold ocup=%0d exp=15", c_ocup);
        end
    endtask

    task automatic test_back_to_back();
        buf_sec = 7'd40; buf_pri = 5'd3; p_qtd = 7'd3;
        p_op_at = 0;
        fork
            begin
                #20;
                p_op_at = 3;
                p_tr_at = 3;
            end
        join_none
        observe(40);
        total++;
        if (grants.size() != 2 || grants[0] !== 2'b01 || grants[1] !== 2'b10) begin
            bad++; $display("FAIL b2b_order n=%0d exp order 01,10", grants.size());
        end
        total++;
        if (c_up != 3 || c_dn != LOTE || c_err != 1 || c_fop != 1 || c_ftr != 1 || c_viol != 0) begin
            bad++;
            $display("FAIL b2b_counts up=%0d dn=%0d err=%0d viol=%0d exp 3 20 1 0", c_up, c_dn, c_err, c_viol);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            run_single(1'($urandom_range(0, 1)), int'($urandom_range(0, 99)), int'($urandom_range(0, 31)), int'($urandom_range(0, 40)), $sformatf("rnd%0d", k));
        end
    endtask

    task automatic test_clr_mid();
        buf_sec = 7'd40; buf_pri = 5'd3; p_tr_at = 0;
        observe(8);
        total++;
        if (c_dn != 6) begin
            bad++; $display("FAIL clr_mid_started got=%0d exp=6", c_dn);
        end
        #2 clr = 1'b0;
        #1;
        total++;
        if (outs() !== 9'd0) begin
            bad++; $display("FAIL clr_mid_abort got=%b exp=0", outs());
        end
        @(posedge clk);
        #1 clr = 1'b1;
        observe(6);
        total++;
        if (c_ocup != 0 || c_viol != 0) begin
            bad++; $display("FAIL clr_mid_after ocup=%0d viol=%0d exp 0 0", c_ocup, c_viol);
        end
    endtask

    initial begin
        test_reset();
        test_operador();
        test_transfer_stall();
        test_arbitration();
        test_reject();
        test_habilita();
        test_back_to_back();
        test_random();
        test_clr_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
